// File: rtl/ibex_rf_cache_pkg.sv
// +-----------------------------------------------------------------------------+
// | ibex_rf_cache_pkg : shared types/constants for the cached register file     |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

package ibex_rf_cache_pkg;

    localparam int unsigned MaxL1Entries = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INST_A = 2'd1,
        INST_B = 2'd2
    } state_e;

    // The data word lives in a parallel array because its width is a module parameter.
    typedef struct packed {
        logic       valid;
        logic [4:0] tag;
    } l1_entry_t;

endpackage

`default_nettype wire

// File: rtl/ibex_rf_l2_bank.sv
// +-----------------------------------------------------------------------------+
// | ibex_rf_l2_bank : single-port backing register bank, 1-cycle sync read      |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module ibex_rf_l2_bank #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned NumRegs   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [4:0]           addr_i,
    input  logic                 we_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic                 re_i,
    output logic [DataWidth-1:0] rdata_o
);

    logic [DataWidth-1:0] r_mem [1:NumRegs-1];
    logic [DataWidth-1:0] r_rdata;
    logic [DataWidth-1:0] w_rd_word;

    // x0 has no storage: writes to it are dropped and reads return zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 1; i < NumRegs; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we_i) begin
            for (int i = 1; i < NumRegs; i++) begin
                if (addr_i == 5'(i)) begin
                    r_mem[i] <= wdata_i;
                end
            end
        end
    end

    always_comb begin
        w_rd_word = '0;
        for (int i = 1; i < NumRegs; i++) begin
            if (addr_i == 5'(i)) begin
                w_rd_word = r_mem[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata <= '0;
        end else if (re_i) begin
            r_rdata <= w_rd_word;
        end
    end

    assign rdata_o = r_rdata;

endmodule

`default_nettype wire

// File: rtl/ibex_cached_regfile.sv
// +-----------------------------------------------------------------------------+
// | ibex_cached_regfile : fully-associative L1 in front of a single-port L2     |
// | bank; optional hit/miss counters with IBEX_RF_CACHE_PERF_EN.  Revision 1.0  |
// +-----------------------------------------------------------------------------+
`default_nettype none

module ibex_cached_regfile
    import ibex_rf_cache_pkg::*;
#(
    parameter int unsigned DataWidth    = 32,
    parameter bit          RV32E        = 1'b0,
    parameter int unsigned NumL1Entries = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
`ifdef IBEX_RF_CACHE_PERF_EN
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o,
`endif
    input  logic [4:0]           raddr_a_i,
    input  logic                 rreq_a_i,
    output logic [DataWidth-1:0] rdata_a_o,
    input  logic [4:0]           raddr_b_i,
    input  logic                 rreq_b_i,
    output logic [DataWidth-1:0] rdata_b_o,
    input  logic [4:0]           waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic                 we_i,
    output logic                 stall_o
);

    localparam int unsigned c_NUM_REGS  = RV32E ? 16 : 32;
    localparam logic [4:0]  c_ADDR_MASK = RV32E ? 5'h0F : 5'h1F;
    localparam logic [2:0]  c_LAST_PTR  = 3'(NumL1Entries - 1);

    logic [4:0]           w_addr_a, w_addr_b, w_waddr;
    l1_entry_t            r_l1      [NumL1Entries];
    logic [DataWidth-1:0] r_l1_data [NumL1Entries];
    logic [2:0]           r_ptr;
    state_e               r_state, w_state_nxt;
    logic [4:0]           r_fill_addr, w_fill_addr_nxt;

    logic                    w_hit_a, w_hit_b, w_miss_a, w_miss_b;
    logic [DataWidth-1:0]    w_rdata_a, w_rdata_b;
    logic [NumL1Entries-1:0] w_wr_hit;
    logic                    w_l2_re, w_install, w_stall;
    logic [4:0]              w_l2_raddr, w_l2_addr;
    logic [DataWidth-1:0]    w_l2_rdata, w_inst_data;

    assign w_addr_a = raddr_a_i & c_ADDR_MASK;
    assign w_addr_b = raddr_b_i & c_ADDR_MASK;
    assign w_waddr  = waddr_i & c_ADDR_MASK;

    // Tag 0 is never installed, so x0 always falls through to the zero default.
    always_comb begin
        w_hit_a   = (w_addr_a == 5'd0);
        w_hit_b   = (w_addr_b == 5'd0);
        w_rdata_a = '0;
        w_rdata_b = '0;
        w_wr_hit  = '0;
        for (int i = 0; i < NumL1Entries; i++) begin
            if (r_l1[i].valid && (r_l1[i].tag == w_addr_a)) begin
                w_hit_a   = 1'b1;
                w_rdata_a = r_l1_data[i];
            end
            if (r_l1[i].valid && (r_l1[i].tag == w_addr_b)) begin
                w_hit_b   = 1'b1;
                w_rdata_b = r_l1_data[i];
            end
            w_wr_hit[i] = we_i && r_l1[i].valid && (r_l1[i].tag == w_waddr);
        end
    end

    assign w_miss_a = rreq_a_i && !w_hit_a;
    assign w_miss_b = rreq_b_i && !w_hit_b;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_fill_addr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_fill_addr <= w_fill_addr_nxt;
        end
    end

    // A write owns the L2 port; any read wanting it that cycle simply waits.
    always_comb begin
        w_state_nxt     = r_state;
        w_fill_addr_nxt = r_fill_addr;
        w_stall         = 1'b0;
        w_l2_re         = 1'b0;
        w_l2_raddr      = w_addr_a;
        w_install       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_miss_a || w_miss_b) begin
                    w_stall = 1'b1;
                    if (!we_i) begin
                        w_l2_re = 1'b1;
                        if (w_miss_a) begin
                            w_l2_raddr  = w_addr_a;
                            w_state_nxt = INST_A;
                        end else begin
                            w_l2_raddr  = w_addr_b;
                            w_state_nxt = INST_B;
                        end
                        w_fill_addr_nxt = w_l2_raddr;
                    end
                end
            end
            INST_A: begin
                w_stall     = 1'b1;
                w_install   = 1'b1;
                w_state_nxt = IDLE;
                // A deferred B fetch is picked up again from IDLE next cycle.
                if (w_miss_b && (w_addr_b != w_addr_a) && !we_i) begin
                    w_l2_re         = 1'b1;
                    w_l2_raddr      = w_addr_b;
                    w_fill_addr_nxt = w_addr_b;
                    w_state_nxt     = INST_B;
                end
            end
            INST_B: begin
                w_stall     = 1'b1;
                w_install   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_l2_addr   = we_i ? w_waddr : w_l2_raddr;
    assign w_inst_data = (we_i && (w_waddr == r_fill_addr)) ? wdata_i : w_l2_rdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumL1Entries; i++) begin
                r_l1[i]      <= '0;
                r_l1_data[i] <= '0;
            end
            r_ptr <= '0;
        end else begin
            for (int i = 0; i < NumL1Entries; i++) begin
                if (w_wr_hit[i]) begin
                    r_l1_data[i] <= wdata_i;
                end
                if (w_install && (r_ptr == 3'(i))) begin
                    r_l1[i].valid <= 1'b1;
                    r_l1[i].tag   <= r_fill_addr;
                    r_l1_data[i]  <= w_inst_data;
                end
            end
            if (w_install) begin
                r_ptr <= (r_ptr == c_LAST_PTR) ? 3'd0 : r_ptr + 3'd1;
            end
        end
    end

    ibex_rf_l2_bank #(
        .DataWidth (DataWidth),
        .NumRegs   (c_NUM_REGS)
    ) u_l2_bank (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .addr_i  (w_l2_addr),
        .we_i    (we_i),
        .wdata_i (wdata_i),
        .re_i    (w_l2_re),
        .rdata_o (w_l2_rdata)
    );

    assign rdata_a_o = w_rdata_a;
    assign rdata_b_o = w_rdata_b;
    assign stall_o   = w_stall;

`ifdef IBEX_RF_CACHE_PERF_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;
    logic [1:0]  w_hit_inc, w_miss_inc;
    logic        w_nz_a, w_nz_b;

    assign w_nz_a     = rreq_a_i && (w_addr_a != 5'd0);
    assign w_nz_b     = rreq_b_i && (w_addr_b != 5'd0);
    assign w_hit_inc  = {1'b0, w_nz_a && w_hit_a} + {1'b0, w_nz_b && w_hit_b};
    assign w_miss_inc = {1'b0, w_nz_a && !w_hit_a} + {1'b0, w_nz_b && !w_hit_b};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_hit_cnt  <= r_hit_cnt + 32'(w_hit_inc);
            r_miss_cnt <= r_miss_cnt + 32'(w_miss_inc);
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

`default_nettype wire
